diffeq_solver_param: RTL and testbench

Parametrised iterative solver for y'' + 3xy' + 3y = 0 using forward-Euler steps. It replaces the fixed-width, strobe-loaded differentiator with the following changes:
- configurable data width
- one addressed load port covering five operands
- an iteration cap with an error flag
- a busy/valid handshake

Operands are loaded serially from the control path. A start pulse launches the iteration on one shared multiplier, and y and u are presented when x reaches the bound a.

---
 rtl/diffeq_pkg.sv | 35 +++
 rtl/diffeq_arith.sv | 47 ++++
 rtl/diffeq_solver_param.sv | 127 ++++++++++++
 tb/tb_diffeq_solver_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/diffeq_pkg.sv
// rtl/diffeq_pkg.sv - shared state enum, load addresses and saturating helpers for the diffeq solver
package diffeq_pkg;

    typedef enum logic [2:0] {IDLE, S_UDX, S_XU, S_YDX, S_UPD, DONE} state_t;

    localparam logic [2:0] ADDR_X  = 3'd0;
    localparam logic [2:0] ADDR_DX = 3'd1;
    localparam logic [2:0] ADDR_A  = 3'd2;
    localparam logic [2:0] ADDR_U  = 3'd3;
    localparam logic [2:0] ADDR_Y  = 3'd4;

    // Helpers work on 64-bit sign-extended values and clip to a w-bit range (w <= 32).
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        return sat_clip(a + b, w);
    endfunction

    function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        return sat_clip(a - b, w);
    endfunction

    function automatic logic signed [63:0] sat_mul(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        return sat_clip(a * b, w);
    endfunction

endpackage

// File: rtl/diffeq_arith.sv
// rtl/diffeq_arith.sv - shared multiplier and update datapath; saturating when DIFFEQ_SAT_EN is defined
module diffeq_arith
    import diffeq_pkg::*;
#(
    parameter int DW = 16
) (
    input  state_t               i_state,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_dx,
    input  logic signed [DW-1:0] i_u,
    input  logic signed [DW-1:0] i_y,
    input  logic signed [DW-1:0] i_p,
    input  logic signed [DW-1:0] i_q,
    input  logic signed [DW-1:0] i_r,
    output logic signed [DW-1:0] o_prod,
    output logic signed [DW-1:0] o_x_new,
    output logic signed [DW-1:0] o_y_new,
    output logic signed [DW-1:0] o_u_new
);

    logic signed [DW-1:0] w_tri_in;
    logic signed [DW-1:0] w_tri;
    logic signed [DW-1:0] w_mul_a;
    logic signed [DW-1:0] w_mul_b;

    // One tripler and one multiplier serve all three product states.
    assign w_tri_in = (i_state == S_XU) ? i_x : i_y;
    assign w_mul_a  = (i_state == S_UDX) ? i_u : w_tri;
    assign w_mul_b  = (i_state == S_XU) ? i_p : i_dx;

`ifdef DIFFEQ_SAT_EN
    logic signed [DW-1:0] w_uq;
    assign w_tri   = DW'(sat_add(64'(w_tri_in) <<< 1, 64'(w_tri_in), DW));
    assign o_prod  = DW'(sat_mul(64'(w_mul_a), 64'(w_mul_b), DW));
    assign w_uq    = DW'(sat_sub(64'(i_u), 64'(i_q), DW));
    assign o_u_new = DW'(sat_sub(64'(w_uq), 64'(i_r), DW));
    assign o_y_new = DW'(sat_add(64'(i_y), 64'(i_p), DW));
    assign o_x_new = DW'(sat_add(64'(i_x), 64'(i_dx), DW));
`else
    assign w_tri   = (w_tri_in <<< 1) + w_tri_in;
    assign o_prod  = w_mul_a * w_mul_b;
    assign o_u_new = i_u - i_q - i_r;
    assign o_y_new = i_y + i_p;
    assign o_x_new = i_x + i_dx;
`endif

endmodule

// File: rtl/diffeq_solver_param.sv
// rtl/diffeq_solver_param.sv - iterative Euler solver for y''+3xy'+3y=0; DIFFEQ_SAT_EN selects saturating math
module diffeq_solver_param
    import diffeq_pkg::*;
#(
    parameter int DW       = 16,
    parameter int MAX_ITER = 255,
    parameter int IW       = $clog2(MAX_ITER + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_en,
    input  logic [2:0]    ld_addr,
    input  logic [DW-1:0] in,
    input  logic          start,
    output logic          busy,
    output logic          valid,
    output logic          err,
    output logic [DW-1:0] out_y,
    output logic [DW-1:0] out_u,
    output logic [IW-1:0] iter_cnt
);

    state_t               r_state;
    logic signed [DW-1:0] r_x, r_dx, r_a, r_u, r_y;
    logic signed [DW-1:0] r_p, r_q, r_r;
    logic        [DW-1:0] r_out_y, r_out_u;
    logic        [IW-1:0] r_cnt;
    logic                 r_busy, r_valid, r_err;

    logic signed [DW-1:0] w_prod, w_x_new, w_y_new, w_u_new;
    logic        [IW-1:0] w_cnt_next;

    assign w_cnt_next = r_cnt + 1'b1;

    diffeq_arith #(.DW(DW)) u_arith (
        .i_state (r_state),
        .i_x     (r_x),
        .i_dx    (r_dx),
        .i_u     (r_u),
        .i_y     (r_y),
        .i_p     (r_p),
        .i_q     (r_q),
        .i_r     (r_r),
        .o_prod  (w_prod),
        .o_x_new (w_x_new),
        .o_y_new (w_y_new),
        .o_u_new (w_u_new)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_x <= '0; r_dx <= '0; r_a <= '0; r_u <= '0; r_y <= '0;
            r_p <= '0; r_q <= '0; r_r <= '0;
            r_out_y <= '0; r_out_u <= '0; r_cnt <= '0;
            r_busy <= 1'b0; r_valid <= 1'b0; r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    // DONE with busy set is the one-cycle zero-iteration completion.
                    if (r_state == DONE && r_busy) begin
                        r_out_y <= r_y;
                        r_out_u <= r_u;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (ld_en) begin
                        case (ld_addr)
                            ADDR_X:  r_x  <= in;
                            ADDR_DX: r_dx <= in;
                            ADDR_A:  r_a  <= in;
                            ADDR_U:  r_u  <= in;
                            ADDR_Y:  r_y  <= in;
                            default: ;
                        endcase
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                    end else if (start) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= (r_x >= r_a) ? DONE : S_UDX;
                    end
                end
                S_UDX: begin
                    r_p     <= w_prod;
                    r_state <= S_XU;
                end
                S_XU: begin
                    r_q     <= w_prod;
                    r_state <= S_YDX;
                end
                S_YDX: begin
                    r_r     <= w_prod;
                    r_state <= S_UPD;
                end
                S_UPD: begin
                    r_u   <= w_u_new;
                    r_y   <= w_y_new;
                    r_x   <= w_x_new;
                    r_cnt <= w_cnt_next;
                    if (w_x_new < r_a && w_cnt_next < IW'(MAX_ITER)) begin
                        r_state <= S_UDX;
                    end else begin
                        r_state <= DONE;
                        r_out_y <= w_y_new;
                        r_out_u <= w_u_new;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_err   <= (w_x_new < r_a);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign err      = r_err;
    assign out_y    = r_out_y;
    assign out_u    = r_out_u;
    assign iter_cnt = r_cnt;

endmodule

// File: tb/tb_diffeq_solver_param.sv
// tb/tb_diffeq_solver_param.sv - randomized self-checking bench for diffeq_solver_param
module tb_diffeq_solver_param;

    localparam int DW       = 16;
    localparam int MAX_ITER = 8;
    localparam int IW       = $clog2(MAX_ITER + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_en = 1'b0;
    logic [2:0]    ld_addr = '0;
    logic [DW-1:0] in = '0;
    logic          start = 1'b0;
    logic          busy, valid, err;
    logic [DW-1:0] out_y, out_u;
    logic [IW-1:0] iter_cnt;

    diffeq_solver_param #(.DW(DW), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .in(in),
        .start(start), .busy(busy), .valid(valid), .err(err),
        .out_y(out_y), .out_u(out_u), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_err    = 0;
    bit     chk_on   = 1'b1;
    longint exp_busy = 0, exp_valid = 0, exp_err = 0, exp_cnt = 0;
    longint exp_out_y = 0, exp_out_u = 0;
    longint sx = 0, sdx = 0, sa = 0, su = 0, sy = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic longint wrapv(input longint v);
        logic [DW-1:0] t;
        t = v[DW-1:0];
        return longint'($signed(t));
    endfunction

    function automatic longint fix(input longint v);
`ifdef DIFFEQ_SAT_EN
        longint hi, lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
`else
        return wrapv(v);
`endif
    endfunction

    // Reference: iterate the Euler recurrence on the shadow operands.
    task automatic model_run(output longint ey, output longint eu, output int en, output longint eerr);
        longint p, q, r;
        en = 0;
        while (sx < sa && en < MAX_ITER) begin
            p  = fix(su * sdx);
            q  = fix(fix(3 * sx) * p);
            r  = fix(fix(3 * sy) * sdx);
            su = fix(fix(su - q) - r);
            sy = fix(sy + p);
            sx = fix(sx + sdx);
            en++;
        end
        eerr = (sx < sa) ? 1 : 0;
        ey = sy;
        eu = su;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", longint'(busy), exp_busy);
            chk("valid", longint'(valid), exp_valid);
            chk("err", longint'(err), exp_err);
            chk("iter_cnt", longint'(iter_cnt), exp_cnt);
            chk("out_y", longint'($signed(out_y)), exp_out_y);
            chk("out_u", longint'($signed(out_u)), exp_out_u);
        end
    end

    task automatic load(input int addr, input longint val, input bit with_start);
        ld_en = 1'b1;
        ld_addr = addr[2:0];
        in = val[DW-1:0];
        start = with_start;
        @(posedge clk); #1;
        ld_en = 1'b0;
        start = 1'b0;
        if (exp_busy == 0) begin
            case (addr)
                0: sx  = wrapv(val);
                1: sdx = wrapv(val);
                2: sa  = wrapv(val);
                3: su  = wrapv(val);
                4: sy  = wrapv(val);
                default: ;
            endcase
            exp_valid = 0;
            exp_err = 0;
        end
    endtask

    task automatic load_all(input longint x, input longint dx, input longint a, input longint u, input longint y);
        load(0, x, 1'b0); load(1, dx, 1'b0); load(2, a, 1'b0); load(3, u, 1'b0); load(4, y, 1'b0);
    endtask

    task automatic run(input bit noise);
        longint ey, eu, eerr;
        int en, lat;
        model_run(ey, eu, en, eerr);
        lat = (en == 0) ? 1 : 4 * en;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_busy = 1; exp_valid = 0; exp_err = 0; exp_cnt = 0;
        for (int k = 1; k <= lat; k++) begin
            if (noise && k == 2 && lat >= 4) begin
                ld_en = 1'b1;
                ld_addr = 3'($urandom_range(4));
                in = DW'($urandom);
                start = 1'b1;
            end
            @(posedge clk); #1;
            ld_en = 1'b0;
            start = 1'b0;
            if (k < lat) begin
                exp_cnt = k / 4;
            end else begin
                exp_busy = 0; exp_valid = 1; exp_cnt = en; exp_err = eerr;
                exp_out_y = ey; exp_out_u = eu;
            end
        end
    endtask

    task automatic check_nominal(input string tag);
        chk({tag, "_y"}, longint'($signed(out_y)), -9819);
`ifdef DIFFEQ_SAT_EN
        chk({tag, "_u"}, longint'($signed(out_u)), 20141);
`else
        chk({tag, "_u"}, longint'($signed(out_u)), -19857);
`endif
        chk({tag, "_cnt"}, longint'(iter_cnt), 4);
        chk({tag, "_err"}, longint'(err), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        load_all(3, 1, 7, 9, 0);
        run(1'b0);
        check_nominal("nominal");

        // Relaunch from DONE reuses updated operands: x reached a, so zero iterations.
        run(1'b0);
        chk("relaunch_y", longint'($signed(out_y)), -9819);
        chk("relaunch_cnt", longint'(iter_cnt), 0);

        load(0, 7, 1'b0);
        chk("valid_drop_on_load", longint'(valid), 0);
        load(2, 7, 1'b0); load(3, 5, 1'b0); load(4, 2, 1'b0);
        run(1'b0);
        chk("zero_u", longint'($signed(out_u)), 5);
        chk("zero_y", longint'($signed(out_y)), 2);
        chk("zero_cnt", longint'(iter_cnt), 0);

        load(0, 0, 1'b0); load(1, 0, 1'b0); load(2, 5, 1'b0);
        run(1'b0);
        chk("cap_err", longint'(err), 1);
        chk("cap_cnt", longint'(iter_cnt), 8);

        load(0, 3, 1'b1);
        chk("ld_start_busy", longint'(busy), 0);

        load_all(3, 1, 7, 9, 0);
        run(1'b1);
        check_nominal("noisy");

        load_all(3, 1, 7, 9, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_busy = 1; exp_valid = 0; exp_err = 0; exp_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            exp_cnt = k / 4;
        end
        reset = 1'b1;
        #1;
        exp_busy = 0; exp_valid = 0; exp_err = 0; exp_cnt = 0; exp_out_y = 0; exp_out_u = 0;
        sx = 0; sdx = 0; sa = 0; su = 0; sy = 0;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_cnt", longint'(iter_cnt), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run(1'b0);
        chk("rst_u_zero", longint'($signed(out_u)), 0);
        chk("rst_valid", longint'(valid), 1);
        load_all(3, 1, 7, 9, 0);
        run(1'b0);
        check_nominal("after_rst");

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(3) != 0) begin
                load_all(longint'($urandom_range(40)) - 20, longint'($urandom_range(4)) - 1,
                         longint'($urandom_range(40)) - 20, longint'($urandom), longint'($urandom));
            end else if ($urandom_range(1) == 1) begin
                load(2, longint'($urandom_range(60)) - 20, 1'b0);
            end
            run(1'($urandom_range(1)));
        end

        @(posedge clk); #1;
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
